// File: rtl/game_pkg.sv
// game_pkg: constants and types shared by the raccoon crossing game blocks
// (game sequencer, raccoon controller, display).
//   - game_state_t : 2-bit game-state encoding driven on o_Game_State
//   - DEF_*        : default parameter values for the sequencer
//   - sat_inc8     : 8-bit saturating increment used for the score
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RUN       = 2'b01,
        ST_GAME_OVER = 2'b10,
        ST_CLEAN     = 2'b11
    } game_state_t;

    localparam int DEF_INIT_LIVES   = 3;
    localparam int DEF_CLEAN_CYCLES = 25_000_000;
    localparam int DEF_SCORE_MAX    = 255;

    // Increment v by one unless it has already reached max.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v >= max) begin
            r = max;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/game_state_ctrl_rise_detect.sv
// rise_detect: single-bit rising-edge detector.
//   i_Clk   : clock
//   i_Reset : synchronous active-high reset, clears the history bit
//   i_Sig   : level input
//   o_Rise  : high in the cycle i_Sig is high and was low on the previous clock
module rise_detect (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Sig,
    output logic o_Rise
);

    logic hist_q;
    logic hist_d;

    // Next history value is simply the current sample.
    always_comb begin
        hist_d = i_Sig;
    end

    // History register of the previous input sample.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign o_Rise = i_Sig & ~hist_q;

endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: top-level game sequencer for the raccoon crossing game.
// Tracks IDLE / RUN / CLEAN / GAME_OVER, lives and score, and tells the
// raccoon controller when to clear its level counter.
//   i_Clk         : system clock
//   i_Reset       : synchronous active-high reset
//   i_Start       : debounced start button (level)
//   i_Collision   : collision flag (level, may stay high)
//   i_Level       : current level from the raccoon controller
//   o_Game_State  : 00 IDLE, 01 RUN, 10 GAME_OVER, 11 CLEAN (registered)
//   o_Reset_Level : level-clear request, high in IDLE and GAME_OVER (registered)
//   o_Lives       : remaining lives (registered)
//   o_Score       : levels completed this game, saturating (registered)
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int INIT_LIVES   = DEF_INIT_LIVES,
    parameter int CLEAN_CYCLES = DEF_CLEAN_CYCLES,
    parameter int SCORE_MAX    = DEF_SCORE_MAX
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Start,
    input  logic       i_Collision,
    input  logic [3:0] i_Level,
    output logic [1:0] o_Game_State,
    output logic       o_Reset_Level,
    output logic [1:0] o_Lives,
    output logic [7:0] o_Score
);

    localparam int              TW         = $clog2(CLEAN_CYCLES);
    localparam logic [TW-1:0]   CLEAN_LAST = TW'(CLEAN_CYCLES - 1);
    localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);
    localparam logic [1:0]      LIVES_INIT = 2'(INIT_LIVES);
    localparam logic [7:0]      SCORE_SAT  = 8'(SCORE_MAX);

    game_state_t   state_q, state_d;
    logic [1:0]    lives_q, lives_d;
    logic [7:0]    score_q, score_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          reset_level_q, reset_level_d;
    logic [3:0]    level_q;
    logic          start_armed_q;

    logic start_rise;
    logic coll_rise;
    logic start_go;
    logic level_up;

    rise_detect u_start_rise (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Sig   (i_Start),
        .o_Rise  (start_rise)
    );

    rise_detect u_coll_rise (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Sig   (i_Collision),
        .o_Rise  (coll_rise)
    );

    // The edge history clears to 0 on reset, so a button held through reset
    // would look like a fresh press. start_armed_q only sets once Start has
    // been seen low, forcing a release-and-press after reset.
    assign start_go = start_rise & start_armed_q;
    assign level_up = (i_Level > level_q);

    // Next-state, lives, score, timer and level-clear computation.
    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        score_d       = score_q;
        timer_d       = timer_q;
        reset_level_d = reset_level_q;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_go) begin
                    state_d = ST_RUN;
                    lives_d = LIVES_INIT;
                    score_d = 8'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                // Level-up and collision are independent; both may apply in one cycle.
                if (level_up) begin
                    score_d = sat_inc8(score_q, SCORE_SAT);
                end else begin
                    score_d = score_q;
                end
                // Lives are at least 1 whenever RUN is entered, so no underflow here.
                if (coll_rise) begin
                    state_d = ST_CLEAN;
                    lives_d = lives_q - 2'd1;
                    timer_d = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CLEAN: begin
                if (timer_q == CLEAN_LAST) begin
                    timer_d = '0;
                    if (lives_q == 2'd0) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        // Level clear is held for the whole of IDLE and GAME_OVER.
        if ((state_d == ST_IDLE) || (state_d == ST_GAME_OVER)) begin
            reset_level_d = 1'b1;
        end else begin
            reset_level_d = 1'b0;
        end
    end

    // State, output and history registers.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q       <= ST_IDLE;
            lives_q       <= LIVES_INIT;
            score_q       <= 8'd0;
            timer_q       <= '0;
            reset_level_q <= 1'b1;
            level_q       <= 4'd0;
            start_armed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            score_q       <= score_d;
            timer_q       <= timer_d;
            reset_level_q <= reset_level_d;
            level_q       <= i_Level;
            start_armed_q <= start_armed_q | ~i_Start;
        end
    end

    assign o_Game_State  = state_q;
    assign o_Reset_Level = reset_level_q;
    assign o_Lives       = lives_q;
    assign o_Score       = score_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed testbench for game_state_ctrl with CLEAN_CYCLES = 16.
// Observed tuple is {state, reset_level, lives, score}.
module tb_game_state_ctrl;

    logic       clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Start = 1'b0;
    logic       i_Collision = 1'b0;
    logic [3:0] i_Level = 4'd0;
    logic [1:0] o_Game_State;
    logic       o_Reset_Level;
    logic [1:0] o_Lives;
    logic [7:0] o_Score;

    int n_cmp  = 0;
    int n_fail = 0;

    game_state_ctrl #(
        .INIT_LIVES   (3),
        .CLEAN_CYCLES (16),
        .SCORE_MAX    (255)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (i_Reset),
        .i_Start       (i_Start),
        .i_Collision   (i_Collision),
        .i_Level       (i_Level),
        .o_Game_State  (o_Game_State),
        .o_Reset_Level (o_Reset_Level),
        .o_Lives       (o_Lives),
        .o_Score       (o_Score)
    );

    always #5 clk = ~clk;

    // Advance n clock edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] obs();
        return {o_Game_State, o_Reset_Level, o_Lives, o_Score};
    endfunction

    function automatic string fmt(input logic [12:0] v);
        return $sformatf("st=%b rl=%b lives=%0d score=%0d", v[12:11], v[10], v[9:8], v[7:0]);
    endfunction

    task automatic test_reset();
        logic [12:0] exp;
        i_Reset = 1'b1;
        step(2);
        exp = {2'b00, 1'b1, 2'd3, 8'd0};
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL reset_values: got %s expected %s", fmt(obs()), fmt(exp));
        end
        i_Reset = 1'b0;
        step(2);
    endtask

    task automatic test_start_held_through_reset();
        logic [12:0] exp;
        i_Start = 1'b1;
        i_Reset = 1'b1;
        step(2);
        i_Reset = 1'b0;
        step(4);
        exp = {2'b00, 1'b1, 2'd3, 8'd0};
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL start_through_reset: got %s expected %s", fmt(obs()), fmt(exp));
        end
        i_Start = 1'b0;
        step(2);
    endtask

    task automatic test_start();
        logic [12:0] exp;
        i_Level = 4'd1;
        i_Start = 1'b1;
        step(1);
        exp = {2'b01, 1'b0, 2'd3, 8'd0};
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL start_to_run: got %s expected %s", fmt(obs()), fmt(exp));
        end
        i_Start = 1'b0;
        step(1);
    endtask

    task automatic test_level_up();
        logic [12:0] exp;
        i_Level = 4'd2;
        step(1);
        exp = {2'b01, 1'b0, 2'd3, 8'd1};
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL level_2: got %s expected %s", fmt(obs()), fmt(exp));
        end
        i_Level = 4'd3;
        step(3);
        exp = {2'b01, 1'b0, 2'd3, 8'd2};
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL level_3_hold: got %s expected %s", fmt(obs()), fmt(exp));
        end
    endtask

    task automatic test_collision_hold();
        logic [12:0] exp;
        i_Collision = 1'b1;
        step(1);
        exp = {2'b11, 1'b0, 2'd2, 8'd2};
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL coll_enter_clean: got %s expected %s", fmt(obs()), fmt(exp));
        end
        for (int i = 2; i <= 16; i++) begin
            step(1);
            n_cmp++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL clean_cycle_%0d: got %s expected %s", i, fmt(obs()), fmt(exp));
            end
        end
        exp = {2'b01, 1'b0, 2'd2, 8'd2};
        for (int i = 17; i <= 100; i++) begin
            step(1);
            n_cmp++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL coll_held_cycle_%0d: got %s expected %s", i, fmt(obs()), fmt(exp));
            end
        end
        i_Collision = 1'b0;
        step(1);
    endtask

    task automatic test_simultaneous();
        logic [12:0] exp;
        i_Collision = 1'b1;
        i_Level = 4'd4;
        step(1);
        i_Collision = 1'b0;
        exp = {2'b11, 1'b0, 2'd1, 8'd3};
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL simul_enter: got %s expected %s", fmt(obs()), fmt(exp));
        end
        step(15);
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL simul_clean_last: got %s expected %s", fmt(obs()), fmt(exp));
        end
        step(1);
        exp = {2'b01, 1'b0, 2'd1, 8'd3};
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL simul_exit: got %s expected %s", fmt(obs()), fmt(exp));
        end
    endtask

    task automatic test_game_over();
        logic [12:0] exp;
        i_Collision = 1'b1;
        step(1);
        i_Collision = 1'b0;
        i_Level = 4'd5;
        exp = {2'b11, 1'b0, 2'd0, 8'd3};
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL last_life_clean: got %s expected %s", fmt(obs()), fmt(exp));
        end
        step(2);
        i_Collision = 1'b1;
        step(1);
        i_Collision = 1'b0;
        step(12);
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL clean_ignores_inputs: got %s expected %s", fmt(obs()), fmt(exp));
        end
        step(1);
        exp = {2'b10, 1'b1, 2'd0, 8'd3};
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL game_over: got %s expected %s", fmt(obs()), fmt(exp));
        end
        step(3);
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL game_over_hold: got %s expected %s", fmt(obs()), fmt(exp));
        end
        i_Start = 1'b1;
        step(1);
        i_Start = 1'b0;
        exp = {2'b01, 1'b0, 2'd3, 8'd0};
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL restart: got %s expected %s", fmt(obs()), fmt(exp));
        end
        step(1);
    endtask

    task automatic test_start_ignored_in_run();
        logic [12:0] exp;
        i_Start = 1'b1;
        step(1);
        i_Start = 1'b0;
        exp = {2'b01, 1'b0, 2'd3, 8'd0};
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL start_in_run: got %s expected %s", fmt(obs()), fmt(exp));
        end
        step(1);
    endtask

    task automatic test_reset_mid_clean();
        logic [12:0] exp;
        i_Collision = 1'b1;
        step(1);
        i_Collision = 1'b0;
        step(4);
        exp = {2'b11, 1'b0, 2'd2, 8'd0};
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL clean_cycle5: got %s expected %s", fmt(obs()), fmt(exp));
        end
        i_Reset = 1'b1;
        step(1);
        i_Reset = 1'b0;
        exp = {2'b00, 1'b1, 2'd3, 8'd0};
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_clean: got %s expected %s", fmt(obs()), fmt(exp));
        end
        step(20);
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL no_pending_exit: got %s expected %s", fmt(obs()), fmt(exp));
        end
        i_Start = 1'b1;
        step(1);
        i_Start = 1'b0;
        exp = {2'b01, 1'b0, 2'd3, 8'd0};
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL start_after_reset: got %s expected %s", fmt(obs()), fmt(exp));
        end
        i_Level = 4'd6;
        step(1);
        exp = {2'b01, 1'b0, 2'd3, 8'd1};
        n_cmp++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL fresh_game_score: got %s expected %s", fmt(obs()), fmt(exp));
        end
    endtask

    task automatic test_score_saturation();
        logic [7:0] exp_score;
        logic [3:0] prev;
        exp_score = 8'd1;
        for (int i = 0; i < 400; i++) begin
            prev = i_Level;
            i_Level = i_Level + 4'd1;
            step(1);
            if ((i_Level > prev) && (exp_score != 8'd255)) begin
                exp_score = exp_score + 8'd1;
            end
            n_cmp++;
            if (o_Score !== exp_score) begin
                n_fail++;
                $display("FAIL score_sat_step_%0d: got %0d expected %0d", i, o_Score, exp_score);
            end
        end
        n_cmp++;
        if (o_Score !== 8'd255 || o_Game_State !== 2'b01 || o_Lives !== 2'd3) begin
            n_fail++;
            $display("FAIL score_saturated: got %s expected st=01 lives=3 score=255", fmt(obs()));
        end
    endtask

    initial begin
        test_reset();
        test_start_held_through_reset();
        test_start();
        test_level_up();
        test_collision_hold();
        test_simultaneous();
        test_game_over();
        test_start_ignored_in_run();
        test_reset_mid_clean();
        test_score_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
